aes_encipher_lanes: RTL
=======================

# aes_encipher_lanes

Parametrised AES encipher datapath: drop-in successor to the single-lane encipher block, with `SBOX_LANES` parallel S-box words per cycle (1, 2 or 4), key length latched at start, a synchronous abort, and a one-cycle completion pulse. It sits between the key memory/key expansion (round keys indexed by `round`) and an external array of `SBOX_LANES` shared 32-bit S-box units. It runs all three key lengths with the same FSM shape.

## Interface
- `SBOX_LANES`, default 1: S-box words processed per SubBytes cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `next` in 1: start request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; sampled only when not in IDLE.
- `keylen` in 2: 0 = AES-128 (Nr=10), 1 = AES-192 (Nr=12), 2 = AES-256 (Nr=14), 3 = treated as AES-192. Captured into `keylen_reg` on the start cycle.
- `round` out 4: current round counter; the round key source must present the key for this index.
- `round_key` in 128: round key for `round`, consumed combinationally.
- `sboxw` out 32*SBOX_LANES: lane i at bits [32i+31:32i]; words to substitute.
- `new_sboxw` in 32*SBOX_LANES: substituted words, same lane mapping, combinational return.
- `block` in 128: plaintext; must be stable during the INIT cycle.
- `new_block` out 128: state register {w0,w1,w2,w3}, with w0 = [127:96].
- `ready` out 1: high when idle and the result is valid.
- `done` out 1: one-cycle pulse when a result is written.

## Operation
- Constant W = 4/SBOX_LANES, the number of SubBytes cycles per round.
- FSM states: IDLE, INIT, SBOX, MAIN.
- **IDLE**
  - On `next`: `round_ctr`<=0, `ready`<=0, `keylen_reg`<=`keylen`, go to INIT.
  - `abort` is ignored in IDLE.
  - `next` outside IDLE is ignored.
- **INIT**
  - state <= `block` ^ `round_key`.
  - `round_ctr`<=1, `sword_ctr`<=0, go to SBOX.
- **SBOX**
  - Lane i drives word index `sword_ctr`*SBOX_LANES+i onto `sboxw`.
  - The same word registers are written from `new_sboxw` lane i in the same cycle.
  - `sword_ctr`++ each cycle. When `sword_ctr`==W-1, go to MAIN.
- **MAIN**
  - `sword_ctr`<=0, `round_ctr`++.
  - If `round_ctr` < Nr: state <= MixColumns(ShiftRows(state)) ^ `round_key`, then go to SBOX.
  - Else (final round): state <= ShiftRows(state) ^ `round_key`, `ready`<=1, `done`<=1 for one cycle, go to IDLE.
- Nr is derived from `keylen_reg` only. Changing `keylen` mid-operation has no effect.
- **abort** in INIT/SBOX/MAIN:
  - Takes priority over every other update.
  - Next state is IDLE; `ready`<=1, `round_ctr`<=0, `sword_ctr`<=0, no `done`.
  - State register holds its current (partial) value; the result is undefined for the user.
- `sboxw` is all zeros outside SBOX.
- GF arithmetic: xtime = {b[6:0],0} ^ (0x1b & {8{b[7]}}). MixColumns and ShiftRows follow FIPS-197 with column-major words.

## Timing
- Reset values: `ready`=1, `done`=0, `round`=0, `new_block`=0, `sboxw`=0, FSM=IDLE, `keylen_reg`=0, `sword_ctr`=0.
- Reset asserted mid-operation forces all of the above immediately (asynchronous); no `done` pulse.
- Latency: `next` sampled at edge E0; `ready`/`done` rise after edge E(1+Nr*(W+1)).
  - AES-128: 51 (L=1), 31 (L=2), 21 (L=4) cycles.
  - AES-192: 61 / 37 / 25 cycles.
  - AES-256: 71 / 43 / 29 cycles.
- `round` sequence:
  - 0 during INIT.
  - k during round k's SBOX and MAIN cycles.
  - Nr+1 after completion, held until the next start.
- `new_block` is stable from `done` until the next INIT.
- `next` asserted in the same cycle that `done` is high: accepted (the FSM is in IDLE), giving back-to-back operation.
- Abort latency: `ready`=1 one cycle after `abort` is sampled.

## Test plan
- FIPS-197 C.1: key 000102..0f, plaintext 00112233445566778899aabbccddeeff -> `new_block` 69c4e0d86a7b0430d8cdb78070b4c55a. `done` must arrive exactly 51/31/21 cycles after `next` for L=1/2/4.
- C.2 (AES-192, key 00..17) -> dda97ca4864cdfe06eaf70a0ec0d7191 in 61/37/25 cycles. Repeat with `keylen`=3 and expect an identical result.
- C.3 (AES-256, key 00..1f) -> 8ea2b7ca516745bfeafc49904b496089. Toggle `keylen` to 0 mid-run: result and latency must be unchanged.
- Assert `abort` in round 5 SBOX -> `ready`=1 next cycle, `round`=0, no `done`. Then C.1 with `next` -> correct result.
- Pulse `next` while busy -> ignored. Assert `next` in the `done` cycle -> second C.1 completes 51 cycles later (L=1).
- Assert `reset_n` low mid-round -> all outputs take their reset values immediately. `sboxw`=0 checked for every non-SBOX cycle.

Source files
------------

// File: rtl/aes_encipher_lanes.sv
// AES encipher datapath with SBOX_LANES parallel S-box words per SubBytes cycle.
// Round keys come from an external source indexed by round; S-box units are external and combinational.
module aes_encipher_lanes #(
    parameter int SBOX_LANES = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     next,
    input  logic                     abort,
    input  logic [1:0]               keylen,
    output logic [3:0]               round,
    input  logic [127:0]             round_key,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    input  logic [127:0]             block,
    output logic [127:0]             new_block,
    output logic                     ready,
    output logic                     done
);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("aes_encipher_lanes: SBOX_LANES must be 1, 2 or 4");
    end

    localparam int unsigned L = SBOX_LANES;
    localparam int unsigned W = 4 / SBOX_LANES;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SBOX,
        MAIN
    } state_e;

    state_e          state_q, state_d;
    logic [3:0][31:0] blk_q, blk_d, sub_blk;
    logic [3:0]      round_q, round_d;
    logic [1:0]      sword_q, sword_d;
    logic [1:0]      keylen_q, keylen_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [3:0]      nr;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    // Row r of column c takes the byte of row r from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = s;
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    always_comb begin
        case (keylen_q)
            2'd0:    nr = 4'd10;
            2'd2:    nr = 4'd14;
            default: nr = 4'd12;
        endcase
    end

    // Word J lives in slot 3-J; it is substituted in cycle J/L through lane J%L.
    for (genvar s = 0; s < 4; s++) begin : g_word
        localparam int unsigned J = 3 - s;
        assign sub_blk[s] = (sword_q == 2'(J / L)) ? new_sboxw[32*(J % L) +: 32] : blk_q[s];
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        logic [1:0] slot;
        assign slot = ~2'(32'(sword_q) * L + 32'(g));
        assign sboxw[32*g +: 32] = (state_q == SBOX) ? blk_q[slot] : '0;
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        round_d  = round_q;
        sword_d  = sword_q;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (next) begin
                    round_d  = '0;
                    ready_d  = 1'b0;
                    keylen_d = keylen;
                    state_d  = INIT;
                end
            end
            INIT: begin
                blk_d   = block ^ round_key;
                round_d = 4'd1;
                sword_d = '0;
                state_d = SBOX;
            end
            SBOX: begin
                blk_d   = sub_blk;
                sword_d = sword_q + 2'd1;
                if (sword_q == 2'(W - 1)) begin
                    state_d = MAIN;
                end
            end
            MAIN: begin
                sword_d = '0;
                round_d = round_q + 4'd1;
                if (round_q < nr) begin
                    blk_d   = mix_columns(shift_rows(blk_q)) ^ round_key;
                    state_d = SBOX;
                end else begin
                    blk_d   = shift_rows(blk_q) ^ round_key;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every update above; the partial state is left as-is.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            blk_d   = blk_q;
            ready_d = 1'b1;
            done_d  = 1'b0;
            round_d = '0;
            sword_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            round_q  <= '0;
            sword_q  <= '0;
            keylen_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            round_q  <= round_d;
            sword_q  <= sword_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign round     = round_q;
    assign new_block = blk_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule
